// File: rtl/hazard_scoreboard.sv
// ============================================================================
// Module  : hazard_scoreboard
// Brief   : Per-register multi-cycle producer scoreboard beside the ID stage;
//           answers stall/go and tracks results not yet forwardable.
// Revision: 1.0
// ============================================================================
`default_nettype none

module hazard_scoreboard #(
  parameter int NUM_REGS   = 32,
  parameter int REG_ADDR_W = 5,
  parameter int LAT_W      = 2,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_rs1,
  input  logic                  issue_rs1_en,
  input  logic [REG_ADDR_W-1:0] issue_rs2,
  input  logic                  issue_rs2_en,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic                  issue_rd_en,
  input  logic [LAT_W-1:0]      issue_lat,
  input  logic                  flush,
  output logic                  stall,
  output logic                  issue_fire,
  output logic [NUM_REGS-1:0]   busy_mask,
  output logic [CNT_W-1:0]      stall_count
);

  localparam int c_ADDR_SPACE = 2 ** REG_ADDR_W;

  // Full-address-space view of the counters; x0 and unimplemented indices read as 0.
  logic [LAT_W-1:0] w_cnt [c_ADDR_SPACE];

  logic w_rs1_nz;
  logic w_rs2_nz;
  logic w_rd_nz;
  logic w_raw1;
  logic w_raw2;
  logic w_waw;
  logic w_stall;
  logic w_fire;
  logic w_alloc;

  assign w_rs1_nz = (issue_rs1 != '0);
  assign w_rs2_nz = (issue_rs2 != '0);
  assign w_rd_nz  = (issue_rd  != '0);

  assign w_raw1 = issue_rs1_en & w_rs1_nz & (w_cnt[issue_rs1] != '0);
  assign w_raw2 = issue_rs2_en & w_rs2_nz & (w_cnt[issue_rs2] != '0);
  // A younger write must not retire before an older one to the same register.
  assign w_waw  = issue_rd_en & w_rd_nz & (w_cnt[issue_rd] > issue_lat);

  assign w_stall = issue_valid & ~flush & (w_raw1 | w_raw2 | w_waw);
  assign w_fire  = issue_valid & ~flush & ~w_stall;
  assign w_alloc = w_fire & issue_rd_en & w_rd_nz & (issue_lat != '0);

  assign stall      = w_stall;
  assign issue_fire = w_fire;

  generate
    for (genvar i = 0; i < c_ADDR_SPACE; i++) begin : g_reg
      if (i == 0 || i >= NUM_REGS) begin : g_zero
        assign w_cnt[i] = '0;
      end else begin : g_track
        logic [LAT_W-1:0] r_cnt;
        logic             w_hit;

        assign w_hit = w_alloc & (issue_rd == REG_ADDR_W'(i));

        always_ff @(posedge clk) begin
          if (rst) begin
            r_cnt <= '0;
          end else if (flush) begin
            r_cnt <= '0;
          end else if (w_hit) begin
            r_cnt <= issue_lat;
          end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end
        end

        assign w_cnt[i] = r_cnt;
      end
    end

    for (genvar j = 0; j < NUM_REGS; j++) begin : g_busy
      assign busy_mask[j] = (w_cnt[j] != '0);
    end
  endgenerate

  logic [CNT_W-1:0] r_stall_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_count <= '0;
    end else if (w_stall && !(&r_stall_count)) begin
      r_stall_count <= r_stall_count + 1'b1;
    end
  end

  assign stall_count = r_stall_count;

endmodule

`default_nettype wire
